// File: rtl/spi_slave_if.sv
// Bus and SPI pin bundle for spi_slave. The master modport is the side that drives the bus and the SPI pins;
// the slave modport is the peripheral side. The tristate mem_data stays a plain port on the peripheral.
interface spi_slave_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_ss;
  logic        spi_miso;

  modport master (output mem_we, mem_addr, spi_sclk, spi_mosi, spi_ss, input spi_miso);
  modport slave  (input mem_we, mem_addr, spi_sclk, spi_mosi, spi_ss, output spi_miso);
endinterface

// File: rtl/spi_slave.sv
// Memory-mapped SPI responder: MSB-first 8-bit frames in all four CPOL/CPHA modes, with DATA/CTRL/STAT registers.
// Optional SPI_SLAVE_IRQ_EN adds a registered spi_irq = CTRL[3] & (rx_valid | overrun).
module spi_slave #(
  parameter logic [31:0] SPIS_BASE = 32'hffff0020
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus,
  inout  wire  [31:0] mem_data
`ifdef SPI_SLAVE_IRQ_EN
  , output logic      spi_irq
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_q, ss_q;
  logic [1:0]  mosi_q;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        cpol_q, cpol_d, cpha_q, cpha_d;
  logic [7:0]  tx_buf_q, tx_buf_d, tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic        tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        reload;

  logic hit_data, hit_ctrl, hit_stat, wr_data, wr_ctrl, rd_data;
  logic en, ss_act, ss_fall, sclk_edge, lead, trail, sample_e, shift_e;
  logic [31:0] rdata;
  logic unused_bus;

  assign hit_data = (bus.mem_addr == SPIS_BASE);
  assign hit_ctrl = (bus.mem_addr == SPIS_BASE + 32'h4);
  assign hit_stat = (bus.mem_addr == SPIS_BASE + 32'h8);
  assign wr_data  = bus.mem_we & hit_data;
  assign wr_ctrl  = bus.mem_we & hit_ctrl;
  assign rd_data  = ~bus.mem_we & hit_data;
  assign unused_bus = ^mem_data[31:8];

  assign en        = ctrl_q[0];
  assign ss_act    = ~ss_q[1];
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign sclk_edge = sclk_q[1] ^ sclk_q[2];
  assign lead      = sclk_edge & (sclk_q[1] != cpol_q);
  assign trail     = sclk_edge & (sclk_q[1] == cpol_q);
  assign sample_e  = cpha_q ? trail : lead;
  assign shift_e   = cpha_q ? lead : trail;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sclk_q <= '0; ss_q <= '0; mosi_q <= '0;
      ctrl_q <= '0; cpol_q <= 1'b0; cpha_q <= 1'b0;
      tx_buf_q <= '0; tx_sr_q <= '0; rx_sr_q <= '0; rx_data_q <= '0;
      tx_full_q <= 1'b0; rx_valid_q <= 1'b0; overrun_q <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sclk_q <= {sclk_q[1:0], bus.spi_sclk};
      ss_q   <= {ss_q[1:0], bus.spi_ss};
      mosi_q <= {mosi_q[0], bus.spi_mosi};
      ctrl_q <= ctrl_d; cpol_q <= cpol_d; cpha_q <= cpha_d;
      tx_buf_q <= tx_buf_d; tx_sr_q <= tx_sr_d; rx_sr_q <= rx_sr_d; rx_data_q <= rx_data_d;
      tx_full_q <= tx_full_d; rx_valid_q <= rx_valid_d; overrun_q <= overrun_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_buf_d   = tx_buf_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    tx_full_d  = tx_full_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    bit_cnt_d  = bit_cnt_q;
    reload     = 1'b0;

    if (wr_ctrl) begin
      ctrl_d = mem_data[3:0];
      if (mem_data[4]) overrun_d = 1'b0;
    end
    if (wr_data) tx_buf_d = mem_data[7:0];
    if (rd_data) rx_valid_d = 1'b0;

    // Losing ss or enable drops any partial byte without touching rx/tx status.
    if (state_q != IDLE && (!en || !ss_act)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (en && ss_fall) begin
          state_d = LOAD;
          reload  = 1'b1;
          cpol_d  = ctrl_q[1];
          cpha_d  = ctrl_q[2];
        end
        LOAD: state_d = SHIFT;
        SHIFT: begin
          if (sample_e) begin
            rx_sr_d   = {rx_sr_q[6:0], mosi_q[1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {rx_sr_q[6:0], mosi_q[1]};
              rx_valid_d = 1'b1;
              if (rx_valid_q && !rd_data) overrun_d = 1'b1;
              reload = 1'b1;
            end
          end else if (shift_e && bit_cnt_q != 3'd0) begin
            // A freshly loaded byte already shows bit 7; the first shift edge of a byte is skipped.
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (reload) begin
      tx_sr_d   = tx_full_q ? tx_buf_q : 8'h00;
      tx_full_d = 1'b0;
      bit_cnt_d = 3'd0;
    end
    if (wr_data) tx_full_d = 1'b1;
  end

  always_comb begin
    rdata = 32'h0;
    if (hit_data)      rdata = {24'h0, rx_data_q};
    else if (hit_ctrl) rdata = {28'h0, ctrl_q};
    else if (hit_stat) rdata = {28'h0, overrun_q, tx_full_q, rx_valid_q, en & ss_act};
  end

  assign mem_data     = (rst && !bus.mem_we && (hit_data || hit_ctrl || hit_stat)) ? rdata : 32'bz;
  assign bus.spi_miso = en & (state_q != IDLE) & tx_sr_q[7];

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= ctrl_q[3] & (rx_valid_q | overrun_q);
  end
  assign spi_irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master plus a byte-level register model; directed cases then random frames.
module tb_spi_slave;
  localparam logic [31:0] BASE   = 32'hffff0020;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_CTRL = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if bus();
  wire  [31:0] mem_data;
  logic        drv = 1'b0;
  logic [31:0] wdata = 32'h0;
  assign mem_data = drv ? wdata : 32'bz;
`ifdef SPI_SLAVE_IRQ_EN
  logic spi_irq;
`endif

  spi_slave #(.SPIS_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_data(mem_data)
`ifdef SPI_SLAVE_IRQ_EN
    , .spi_irq(spi_irq)
`endif
  );

  int nvec = 0, nerr = 0;
  logic [3:0] m_ctrl;
  logic [7:0] m_txbuf, m_rx;
  logic       m_txf, m_rv, m_ov;
  logic       cur_cpol, cur_cpha;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_ctrl = 4'h0; m_txbuf = 8'h0; m_rx = 8'h0; m_txf = 1'b0; m_rv = 1'b0; m_ov = 1'b0;
  endtask

  function automatic logic [31:0] stat_exp(input logic busy);
    return {28'h0, m_ov, m_txf, m_rv, busy};
  endfunction

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_we = 1'b1; bus.mem_addr = a; wdata = d; drv = 1'b1;
    @(negedge clk);
    bus.mem_we = 1'b0; bus.mem_addr = 32'h0; drv = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    bus_wr(A_CTRL, {24'h0, d});
    m_ctrl = d[3:0];
    if (d[4]) m_ov = 1'b0;
  endtask

  task automatic wr_data(input logic [7:0] d);
    bus_wr(A_DATA, {24'h0, d});
    m_txbuf = d; m_txf = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    @(negedge clk);
    bus.mem_addr = a;
    #1 v = mem_data;
    @(negedge clk);
    bus.mem_addr = 32'h0;
    chk(tag, v, exp);
    if (a == A_DATA) m_rv = 1'b0;
  endtask

  task automatic spi_start();
    cur_cpol = m_ctrl[1]; cur_cpha = m_ctrl[2];
    bus.spi_sclk = cur_cpol;
    tick(4);
    bus.spi_ss = 1'b0;
    tick(H);
  endtask

  task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cur_cpha) bus.spi_mosi = mo[7-i];
      tick(H);
      bus.spi_sclk = ~cur_cpol;
      if (cur_cpha) bus.spi_mosi = mo[7-i];
      else          mi[7-i] = bus.spi_miso;
      tick(H);
      bus.spi_sclk = cur_cpol;
      if (cur_cpha) mi[7-i] = bus.spi_miso;
    end
  endtask

  task automatic frame(input int nb, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] mo, mi, ex;
    spi_start();
    for (int k = 0; k < nb; k++) begin
      mo = (k == 0) ? b0 : b1;
      ex = m_txf ? m_txbuf : 8'h00;
      m_txf = 1'b0;
      spi_byte(mo, 8, mi);
      chk("miso_byte", {24'h0, mi}, {24'h0, ex});
      if (m_rv) m_ov = 1'b1;
      m_rv = 1'b1; m_rx = mo;
    end
  endtask

  task automatic post();
    tick(H);
    rd_chk("stat_in_frame", A_STAT, stat_exp(m_ctrl[0]));
    bus.spi_ss = 1'b1;
    tick(4);
    rd_chk("stat_after_frame", A_STAT, stat_exp(1'b0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi, b0, b1;
    logic [7:0] c;
    bus.mem_we = 1'b0; bus.mem_addr = 32'h0;
    bus.spi_sclk = 1'b0; bus.spi_mosi = 1'b0; bus.spi_ss = 1'b1;
    model_reset();
    tick(3);
    chk("miso_in_reset", {31'h0, bus.spi_miso}, 32'h0);
`ifdef SPI_SLAVE_IRQ_EN
    chk("irq_in_reset", {31'h0, spi_irq}, 32'h0);
`endif
    rst = 1'b1;
    tick(2);
    rd_chk("stat_reset", A_STAT, 32'h0);
    rd_chk("ctrl_reset", A_CTRL, 32'h0);
    rd_chk("data_reset", A_DATA, 32'h0);

    // mode 0
    wr_ctrl(8'h01); wr_data(8'hA5);
    rd_chk("stat_txfull", A_STAT, 32'h4);
    frame(1, 8'h3C, 8'h00);
    post();
    rd_chk("data_mode0", A_DATA, 32'h3C);
    rd_chk("stat_rx_cleared", A_STAT, 32'h0);

    // mode 3
    wr_ctrl(8'h07); wr_data(8'h81);
    rd_chk("ctrl_rb", A_CTRL, 32'h7);
    frame(1, 8'hF0, 8'h00);
    post();
    rd_chk("data_mode3", A_DATA, 32'hF0);

    // back-to-back under one ss, single tx_buf load
    wr_ctrl(8'h01); wr_data(8'h5A);
    frame(2, 8'h11, 8'h22);
    post();
    rd_chk("data_b2b", A_DATA, 32'h22);
    wr_ctrl(8'h11);
    rd_chk("stat_ov_clear", A_STAT, 32'h0);

    // abort mid-byte, then a clean frame
    spi_start();
    m_txf = 1'b0;
    spi_byte(8'hC3, 4, mi);
    post();
    frame(1, 8'h99, 8'h00);
    post();
    rd_chk("data_after_abort", A_DATA, 32'h99);

    // reset mid-frame, then frames are ignored until enable is rewritten
    wr_data(8'hE7);
    spi_start();
    spi_byte(8'h6B, 3, mi);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    model_reset();
    #1 chk("miso_after_rst", {31'h0, bus.spi_miso}, 32'h0);
    bus.spi_ss = 1'b1;
    tick(4);
    rd_chk("stat_after_rst", A_STAT, 32'h0);
    rd_chk("ctrl_after_rst", A_CTRL, 32'h0);
    spi_start();
    spi_byte(8'h77, 8, mi);
    chk("miso_disabled", {24'h0, mi}, 32'h0);
    post();

`ifdef SPI_SLAVE_IRQ_EN
    wr_ctrl(8'h09);
    frame(1, 8'h42, 8'h00);
    post();
    chk("irq_set", {31'h0, spi_irq}, 32'h1);
    rd_chk("data_irq", A_DATA, 32'h42);
    chk("irq_hold", {31'h0, spi_irq}, 32'h1);
    tick(1);
    chk("irq_drop", {31'h0, spi_irq}, 32'h0);
`endif

    // random frames against the model
    for (int it = 0; it < 24; it++) begin
      c = 8'h01 | 8'($urandom_range(0, 3) << 1) | 8'($urandom_range(0, 1) << 3);
      wr_ctrl(c);
      if ($urandom_range(0, 1) == 1) wr_data(8'($urandom));
      b0 = 8'($urandom); b1 = 8'($urandom);
      frame(int'($urandom_range(1, 2)), b0, b1);
      post();
`ifdef SPI_SLAVE_IRQ_EN
      chk("irq_rand", {31'h0, spi_irq}, {31'h0, m_ctrl[3] & (m_rv | m_ov)});
`endif
      if ($urandom_range(0, 1) == 1) rd_chk("data_rand", A_DATA, {24'h0, m_rx});
      if (m_ov && $urandom_range(0, 1) == 1) begin
        wr_ctrl({4'h1, m_ctrl});
        rd_chk("stat_ov_rand", A_STAT, stat_exp(1'b0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
